// File: rtl/lift_sched_ctrl.sv
// Single-car SCAN sequencer: latches hall/car calls, keeps direction while calls lie ahead,
// times floor-to-floor travel and door dwell, and drives motion/door outputs.
module lift_sched_ctrl #(
  parameter int unsigned FLOORS        = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  out_buttons,
  input  logic [FLOORS-1:0]  in_buttons,
  output logic [FLOOR_W-1:0] current_floor,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               goingUp,
  output logic               goingDown,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int unsigned TmrMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax);
  localparam logic [TmrW-1:0] TravelLast = TmrW'(TRAVEL_CYCLES - 1);
  localparam logic [TmrW-1:0] DoorLast   = TmrW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] cur_q, cur_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [FLOORS-1:0]  pend_q, pend_d;
  logic               up_q, up_d;

  logic [FLOORS-1:0]  btn, cur_mask, arr_mask, set_mask, clr_mask, dec_clr;
  logic [FLOOR_W-1:0] arr_floor, up_near, dn_near;
  logic               up_any, dn_any, ahead_any, behind_any;
  state_e             dec_state;
  logic               dec_up;

  assign btn       = out_buttons | in_buttons;
  assign cur_mask  = FLOORS'(1) << cur_q;
  assign arr_floor = up_q ? cur_q + 1'b1 : cur_q - 1'b1;
  assign arr_mask  = FLOORS'(1) << arr_floor;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    up_any  = 1'b0;
    up_near = cur_q;
    dn_any  = 1'b0;
    dn_near = cur_q;
    for (int i = int'(FLOORS) - 1; i >= 0; i--) begin
      if (pend_q[i] && (FLOOR_W'(i) > cur_q)) begin
        up_any  = 1'b1;
        up_near = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (pend_q[i] && (FLOOR_W'(i) < cur_q)) begin
        dn_any  = 1'b1;
        dn_near = FLOOR_W'(i);
      end
    end
  end

  assign ahead_any  = up_q ? up_any : dn_any;
  assign behind_any = up_q ? dn_any : up_any;

  // Decision rule shared by IDLE and door close.
  always_comb begin
    dec_state = StIdle;
    dec_up    = up_q;
    dec_clr   = '0;
    if (|(pend_q & cur_mask)) begin
      dec_state = StDoor;
      dec_clr   = cur_mask;
    end else if (ahead_any) begin
      dec_state = StMove;
    end else if (behind_any) begin
      dec_state = StMove;
      dec_up    = ~up_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      tmr_q   <= '0;
      pend_q  <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      up_q    <= up_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tmr_d    = tmr_q;
    up_d     = up_q;
    set_mask = btn;
    clr_mask = '0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d  = dec_state;
          up_d     = dec_up;
          clr_mask = dec_clr;
          tmr_d    = '0;
        end
      end
      StMove: begin
        if (tmr_q == TravelLast) begin
          tmr_d = '0;
          cur_d = arr_floor;
          if (|(pend_q & arr_mask)) begin
            state_d  = StDoor;
            clr_mask = arr_mask;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDoor: begin
        // A call at the open floor extends the dwell instead of latching.
        if (|(btn & cur_mask)) begin
          set_mask = btn & ~cur_mask;
          tmr_d    = '0;
        end else if (tmr_q == DoorLast) begin
          state_d  = dec_state;
          up_d     = dec_up;
          clr_mask = dec_clr;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    pend_d = (pend_q | set_mask) & ~clr_mask;
  end

  always_comb begin
    current_floor = cur_q;
    pending       = pend_q;
    goingUp       = (state_q == StMove) && up_q;
    goingDown     = (state_q == StMove) && !up_q;
    door_open     = (state_q == StDoor);
    if (pend_q == '0) begin
      next_floor = cur_q;
    end else if (ahead_any) begin
      next_floor = up_q ? up_near : dn_near;
    end else if (behind_any) begin
      next_floor = up_q ? dn_near : up_near;
    end else begin
      next_floor = cur_q;
    end
  end

`ifndef SYNTHESIS
  a_floor_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == StMove && tmr_q == TravelLast) |->
      (up_q ? (cur_q != FLOOR_W'(FLOORS - 1)) : (cur_q != '0)));
`endif

endmodule

// File: tb/tb_lift_sched_ctrl.sv
// Randomized bench for lift_sched_ctrl against an event-level SCAN model, plus directed
// scenarios for latency, dwell extension, service order and asynchronous reset.
module tb_lift_sched_ctrl;

  localparam int F  = 8;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [F-1:0]  out_buttons = '0;
  logic [F-1:0]  in_buttons = '0;
  logic [FW-1:0] current_floor, next_floor;
  logic          goingUp, goingDown, door_open;
  logic [F-1:0]  pending;

  lift_sched_ctrl #(
    .FLOORS       (F),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .out_buttons  (out_buttons),
    .in_buttons   (in_buttons),
    .current_floor(current_floor),
    .next_floor   (next_floor),
    .goingUp      (goingUp),
    .goingDown    (goingDown),
    .door_open    (door_open),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: car position, signed motion (+1/-1/0), remembered direction,
  // remaining travel/dwell cycles and the set of outstanding calls.
  int           m_floor, m_mem, m_mov, m_tl, m_dl;
  bit           m_door;
  logic [F-1:0] m_pend;

  function automatic int nearest(input logic [F-1:0] p, input int from, input int dir);
    for (int f = from + dir; f >= 0 && f < F; f += dir) begin
      if (p[f]) return f;
    end
    return -1;
  endfunction

  function automatic int m_next();
    int n;
    if (m_pend == '0) return m_floor;
    n = nearest(m_pend, m_floor, m_mem);
    if (n < 0) n = nearest(m_pend, m_floor, -m_mem);
    if (n < 0) n = m_floor;
    return n;
  endfunction

  task automatic m_reset();
    m_floor = 0; m_mem = 1; m_mov = 0; m_tl = 0; m_dl = 0; m_door = 0; m_pend = '0;
  endtask

  task automatic m_decide(input logic [F-1:0] p0, inout logic [F-1:0] clr);
    if (p0[m_floor]) begin
      clr[m_floor] = 1'b1;
      m_door = 1;
      m_dl = DC;
    end else if (nearest(p0, m_floor, m_mem) >= 0) begin
      m_mov = m_mem;
      m_tl = TC;
    end else if (nearest(p0, m_floor, -m_mem) >= 0) begin
      m_mem = -m_mem;
      m_mov = m_mem;
      m_tl = TC;
    end
  endtask

  task automatic m_step(input logic [F-1:0] btn);
    logic [F-1:0] p0, np, clr;
    p0 = m_pend;
    np = m_pend | btn;
    clr = '0;
    if (m_door) begin
      if (btn[m_floor]) begin
        m_dl = DC;
        np[m_floor] = p0[m_floor];
      end else begin
        m_dl--;
        if (m_dl == 0) begin
          m_door = 0;
          m_decide(p0, clr);
        end
      end
    end else if (m_mov != 0) begin
      m_tl--;
      if (m_tl == 0) begin
        m_floor += m_mov;
        m_tl = TC;
        if (p0[m_floor]) begin
          clr[m_floor] = 1'b1;
          m_mov = 0;
          m_door = 1;
          m_dl = DC;
        end
      end
    end else if (p0 != '0) begin
      m_decide(p0, clr);
    end
    m_pend = np & ~clr;
  endtask

  task automatic compare_all();
    check_val("cur_floor", int'(current_floor), m_floor);
    check_val("next_floor", int'(next_floor), m_next());
    check_val("going_up", int'(goingUp), int'(m_mov == 1));
    check_val("going_down", int'(goingDown), int'(m_mov == -1));
    check_val("door_open", int'(door_open), int'(m_door));
    check_val("pending", int'(pending), int'(m_pend));
  endtask

  // Entered and left at a falling edge; inputs are held across one rising edge.
  task automatic tick(input logic [F-1:0] ob, input logic [F-1:0] ib);
    out_buttons = ob;
    in_buttons  = ib;
    @(posedge clk);
    if (!rst) m_step(ob | ib);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    out_buttons = '0;
    in_buttons = '0;
    m_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  int stops[$];

  task automatic run_record(input int n);
    bit prev;
    stops.delete();
    prev = door_open;
    for (int i = 0; i < n; i++) begin
      if (door_open && !prev) stops.push_back(int'(current_floor));
      prev = door_open;
      tick('0, '0);
    end
  endtask

  task automatic sc_single();
    int up_cnt, door_cnt, guard;
    tick('0, 8'b0000_1000);
    check_val("s1_up_early", int'(goingUp), 0);
    tick('0, '0);
    check_val("s1_up_rise", int'(goingUp), 1);
    up_cnt = 0;
    guard = 0;
    while (current_floor != 3 && guard < 100) begin
      if (goingUp) up_cnt++;
      guard++;
      tick('0, '0);
    end
    check_val("s1_reach3", int'(current_floor), 3);
    check_val("s1_up_cycles", up_cnt, 12);
    door_cnt = 0;
    guard = 0;
    while (door_open && guard < 100) begin
      door_cnt++;
      guard++;
      tick('0, '0);
    end
    check_val("s1_door_cycles", door_cnt, 6);
    check_val("s1_pend_clear", int'(pending), 0);
    check_val("s1_idle_dirs", int'(goingUp | goingDown), 0);
  endtask

  initial begin
    int guard, door_cnt;
    logic [F-1:0] ob, ib;
    int r;
    m_reset();
    @(negedge clk);
    do_reset();

    sc_single();

    // Dwell extension at floor 3: press again on the 4th dwell cycle.
    tick('0, 8'b0000_1000);
    tick('0, '0);
    check_val("ext_door_opens", int'(door_open), 1);
    door_cnt = 1;
    for (int i = 0; i < 3; i++) begin
      tick('0, '0);
      if (door_open) door_cnt++;
    end
    tick(8'b0000_1000, '0);
    check_val("ext_pend_bit", int'(pending[3]), 0);
    guard = 0;
    while (door_open && guard < 100) begin
      door_cnt++;
      guard++;
      tick('0, '0);
    end
    check_val("ext_door_cycles", door_cnt, 10);

    // Two calls latched together from floor 0.
    do_reset();
    tick('0, 8'b0100_0010);
    check_val("dual_latch", int'(pending), 8'b0100_0010);
    run_record(80);
    check_val("dual_nstops", stops.size(), 2);
    check_val("dual_first", (stops.size() > 0) ? stops[0] : -1, 1);
    check_val("dual_second", (stops.size() > 1) ? stops[1] : -1, 6);

    // SCAN: moving up past 2 with calls at 5 and 1.
    do_reset();
    tick('0, 8'b0010_0000);
    guard = 0;
    while (!(current_floor == 2 && goingUp) && guard < 100) begin
      guard++;
      tick('0, '0);
    end
    tick(8'b0000_0010, '0);
    check_val("scan_next5", int'(next_floor), 5);
    run_record(80);
    check_val("scan_first", (stops.size() > 0) ? stops[0] : -1, 5);
    check_val("scan_second", (stops.size() > 1) ? stops[1] : -1, 1);

    // Dwelling at 4 with memory up, calls at 0 and 7.
    do_reset();
    tick('0, 8'b0001_0000);
    guard = 0;
    while (!door_open && guard < 100) begin
      guard++;
      tick('0, '0);
    end
    tick(8'b1000_0001, '0);
    run_record(100);
    check_val("dwell4_first", (stops.size() > 0) ? stops[0] : -1, 7);
    check_val("dwell4_second", (stops.size() > 1) ? stops[1] : -1, 0);

    // Press the target floor on the arrival edge.
    do_reset();
    tick('0, 8'b0000_1000);
    guard = 0;
    while (!(m_floor == 2 && m_mov == 1 && m_tl == 1) && guard < 100) begin
      guard++;
      tick('0, '0);
    end
    tick('0, 8'b0000_1000);
    check_val("arr_door", int'(door_open), 1);
    check_val("arr_pend_bit", int'(pending[3]), 0);
    run_record(20);
    check_val("arr_reopen", stops.size(), 0);

    // Reset between floors 2 and 3 with calls outstanding, then a fresh call.
    do_reset();
    tick('0, 8'b0010_0000);
    guard = 0;
    while (!(current_floor == 2 && goingUp) && guard < 100) begin
      guard++;
      tick('0, '0);
    end
    tick('0, 8'b1000_0000);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async_pend", int'(pending), 0);
    check_val("rst_async_up", int'(goingUp), 0);
    check_val("rst_async_floor", int'(current_floor), 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    sc_single();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      ob = '0;
      ib = '0;
      r = int'($urandom_range(0, 15));
      if (r == 0) ib[$urandom_range(0, F - 1)] = 1'b1;
      if (r == 1) ob[$urandom_range(0, F - 1)] = 1'b1;
      if (r == 2) ob = F'($urandom) & F'($urandom) & F'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick(ob, ib);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
